fp_mac_driver: RTL and testbench
================================

FP_MAC_DRIVER -- requirements
Module: fp_mac_driver

Interface
REQ-001 SHALL have parameter OPW, default 16, operand/result width in bits (multiple of 8, 8..32).
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles without mac_rvalid before abort.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port op_valid  input  1  operand pair offered.
REQ-006 SHALL have port op_ready  output  1  operand pair accepted when op_valid&op_ready.
REQ-007 SHALL have port op_a  input  OPW  multiplicand (FP, MSB-first encoding).
REQ-008 SHALL have port op_b  input  OPW  multiplier.
REQ-009 SHALL have port op_last  input  1  final pair of accumulation; request result afterwards.
REQ-010 SHALL have port mac_data  output  8  byte to MAC dedicated inputs.
REQ-011 SHALL have port mac_strb  output  1  mac_data/mac_cmd valid this cycle.
REQ-012 SHALL have port mac_cmd  output  2  00 idle, 01 A byte, 10 B byte, 11 read result.
REQ-013 SHALL have port mac_rdata  input  8  result byte from MAC outputs.
REQ-014 SHALL have port mac_rvalid  input  1  mac_rdata valid.
REQ-015 SHALL have port res_valid  output  1  result available.
REQ-016 SHALL have port res_ready  input  1  result consumed when res_valid&res_ready.
REQ-017 SHALL have port res_data  output  OPW  assembled accumulator result.
REQ-018 SHALL have port res_err  output  1  result aborted by timeout (qualified by res_valid).
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement FSM IDLE, SEND_A, SEND_B, REQ, RECV, HOLD; all outputs registered.
REQ-021 op_ready SHALL be 1 only in IDLE; acceptance captures op_a, op_b, op_last and enters SEND_A.
REQ-022 SEND_A SHALL drive OPW/8 consecutive cycles, mac_strb=1, mac_cmd=01, bytes of op_a MSB first; then SEND_B likewise with cmd=10 and op_b.
REQ-023 After SEND_B: op_last=0 -> IDLE; op_last=1 -> REQ.
REQ-024 Non-last latency: accept at cycle 0, bytes on cycles 1..2*OPW/8, op_ready high on cycle 2*OPW/8+1.
REQ-025 REQ SHALL last exactly one cycle with mac_strb=1, mac_cmd=11, mac_data=0, then enter RECV.
REQ-026 RECV SHALL shift in OPW/8 bytes on mac_rvalid cycles, MSB first; after last byte enter HOLD with res_valid=1, res_err=0.
REQ-027 A timeout counter SHALL clear on entering REQ and on each mac_rvalid in RECV; reaching TIMEOUT in RECV -> HOLD with res_err=1, res_data=0.
REQ-028 HOLD SHALL keep res_valid, res_data, res_err stable until res_ready; on handshake return to IDLE the next cycle.
REQ-029 mac_rvalid outside RECV SHALL be ignored with no state change.
REQ-030 Outside SEND_A/SEND_B/REQ mac_strb=0, mac_cmd=00, mac_data=0.
REQ-031 op_valid in non-IDLE states SHALL be ignored (no capture).

Reset
REQ-032 rst asserted SHALL immediately force IDLE, counters/shift registers 0, op_ready=1, mac_strb=0, mac_cmd=00, mac_data=0, res_valid=0, res_err=0, res_data=0, busy=0.
REQ-033 Reset mid-transfer SHALL abandon the transaction; no partial result is ever presented.

Structure
REQ-034 Shared package fp_mac_pkg SHALL hold the FSM state enum and mac_cmd code constants (CMD_IDLE, CMD_A, CMD_B, CMD_RD).
REQ-035 One sub-module fp_mac_byte_ser (load OPW word, shift out MSB byte per enable, byte index count) SHALL be used for SEND_A/SEND_B; receive path stays inline.

Verification
REQ-036 A=0x3F80, B=0x4000, last=0 -> mac_data 3F,80,40,00 with cmd 01,01,10,10 on cycles 1-4, op_ready high cycle 5.
REQ-037 A=0x4000, B=0x4040, last=1, MAC returns 0x40 then 0xC0 with 3 idle cycles between -> one REQ cycle cmd=11, res_data=0x40C0, res_err=0.
REQ-038 last=1, mac_rvalid held 0 -> res_valid with res_err=1, res_data=0 exactly TIMEOUT cycles after REQ.
REQ-039 res_ready low 10 cycles in HOLD, op_valid high throughout -> res_data stable, op_ready=0 until handshake.
REQ-040 rst pulsed during second SEND_B byte -> all outputs reset values asynchronously; next op transfers cleanly from byte 0.
REQ-041 mac_rvalid=1 with mac_rdata=0xFF while IDLE -> no state change, res_valid stays 0.

Source files
------------

// File: rtl/fp_mac_pkg.sv
// Shared definitions for the FP MAC byte-interface driver: FSM states and
// the command codes placed on mac_cmd.
package fp_mac_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND_A,
      SEND_B,
      REQ,
      RECV,
      HOLD
   } state_t;

   localparam logic [1:0] CMD_IDLE = 2'b00;
   localparam logic [1:0] CMD_A    = 2'b01;
   localparam logic [1:0] CMD_B    = 2'b10;
   localparam logic [1:0] CMD_RD   = 2'b11;

   function automatic logic [1:0] cmd_of(input state_t s);
      case (s)
         SEND_A:  return CMD_A;
         SEND_B:  return CMD_B;
         REQ:     return CMD_RD;
         default: return CMD_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/fp_mac_byte_ser.sv
// Word-to-byte serializer: loads an OPW-bit word and presents its bytes
// MSB first, advancing one byte per shift; shifts in zeros so it idles at 0.
module fp_mac_byte_ser #(
   parameter int OPW = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [OPW-1:0] word,
   input  logic           shift,
   output logic [7:0]     byte_out,
   output logic           last
);

   localparam int NB = OPW / 8;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

   logic [OPW-1:0] sreg;
   logic [IW-1:0]  idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg <= '0;
         idx  <= '0;
      end else if (load) begin
         sreg <= word;
         idx  <= '0;
      end else if (shift) begin
         sreg <= sreg << 8;
         idx  <= idx + IW'(1);
      end
   end

   assign byte_out = sreg[OPW-1 -: 8];
   assign last     = (idx == LAST_IDX);

endmodule

// File: rtl/fp_mac_driver.sv
// Drives an FP multiply-accumulate unit over a byte-wide command port:
// streams operand pairs, optionally reads back the accumulator with timeout.
module fp_mac_driver
   import fp_mac_pkg::*;
#(
   parameter int OPW     = 16,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           op_valid,
   output logic           op_ready,
   input  logic [OPW-1:0] op_a,
   input  logic [OPW-1:0] op_b,
   input  logic           op_last,
   output logic [7:0]     mac_data,
   output logic           mac_strb,
   output logic [1:0]     mac_cmd,
   input  logic [7:0]     mac_rdata,
   input  logic           mac_rvalid,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [OPW-1:0] res_data,
   output logic           res_err,
   output logic           busy
);

   localparam int NB = OPW / 8;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] RX_LAST = IW'(NB - 1);
   localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);

   state_t         state, state_nxt;
   logic [OPW-1:0] b_q;
   logic           last_q;
   logic [OPW-1:0] rx_q, rx_nxt;
   logic [IW-1:0]  rx_cnt;
   logic [TW-1:0]  tmo_cnt, tmo_inc;
   logic           rx_done, tmo_hit;
   logic           capture, ser_load, ser_shift, ser_last;
   logic [OPW-1:0] ser_word;

   fp_mac_byte_ser #(.OPW(OPW)) u_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (ser_load),
      .word     (ser_word),
      .shift    (ser_shift),
      .byte_out (mac_data),
      .last     (ser_last)
   );

   assign rx_nxt  = (rx_q << 8) | OPW'(mac_rdata);
   assign rx_done = mac_rvalid && (rx_cnt == RX_LAST);
   assign tmo_inc = tmo_cnt + TW'(1);
   // A returning byte in the same cycle as the limit takes precedence.
   assign tmo_hit = !mac_rvalid && (tmo_inc == TMO_LIM);

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      ser_load  = 1'b0;
      ser_word  = op_a;
      ser_shift = 1'b0;
      case (state)
         IDLE: begin
            if (op_valid && op_ready) begin
               capture   = 1'b1;
               ser_load  = 1'b1;
               state_nxt = SEND_A;
            end
         end
         SEND_A: begin
            if (ser_last) begin
               ser_load  = 1'b1;
               ser_word  = b_q;
               state_nxt = SEND_B;
            end else begin
               ser_shift = 1'b1;
            end
         end
         SEND_B: begin
            // Final shift empties the serializer so mac_data returns to 0.
            ser_shift = 1'b1;
            if (ser_last) state_nxt = last_q ? REQ : IDLE;
         end
         REQ:  state_nxt = RECV;
         RECV: if (rx_done || tmo_hit) state_nxt = HOLD;
         HOLD: if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         b_q       <= '0;
         last_q    <= 1'b0;
         rx_q      <= '0;
         rx_cnt    <= '0;
         tmo_cnt   <= '0;
         op_ready  <= 1'b1;
         busy      <= 1'b0;
         mac_strb  <= 1'b0;
         mac_cmd   <= CMD_IDLE;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            b_q    <= op_b;
            last_q <= op_last;
         end

         if (state_nxt == REQ) begin
            rx_q    <= '0;
            rx_cnt  <= '0;
            tmo_cnt <= '0;
         end else if (state == RECV && mac_rvalid) begin
            rx_q    <= rx_nxt;
            rx_cnt  <= rx_cnt + IW'(1);
            tmo_cnt <= '0;
         end else if (state == REQ || state == RECV) begin
            tmo_cnt <= tmo_inc;
         end

         if (state == RECV && state_nxt == HOLD) begin
            res_data <= rx_done ? rx_nxt : '0;
            res_err  <= !rx_done;
         end else if (state == HOLD && state_nxt == IDLE) begin
            res_data <= '0;
            res_err  <= 1'b0;
         end

         op_ready  <= (state_nxt == IDLE);
         busy      <= (state_nxt != IDLE);
         mac_strb  <= (state_nxt == SEND_A) || (state_nxt == SEND_B) || (state_nxt == REQ);
         mac_cmd   <= cmd_of(state_nxt);
         res_valid <= (state_nxt == HOLD);
      end
   end

endmodule

// File: tb/tb_fp_mac_driver.sv
// Directed self-checking bench for fp_mac_driver (OPW=16).
module tb_fp_mac_driver;

   localparam int OPW = 16;
   localparam int TMO = 255;

   logic           clk = 1'b0, rst = 1'b0;
   logic           op_valid = 1'b0, op_last = 1'b0;
   logic           op_ready;
   logic [OPW-1:0] op_a = '0, op_b = '0;
   logic [7:0]     mac_data, mac_rdata = '0;
   logic           mac_strb, mac_rvalid = 1'b0;
   logic [1:0]     mac_cmd;
   logic           res_valid, res_ready = 1'b0, res_err, busy;
   logic [OPW-1:0] res_data;

   int errors = 0;
   int checks = 0;
   int rd_cycles = 0;

   always #5 clk = ~clk;

   fp_mac_driver #(.OPW(OPW), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .op_last    (op_last),
      .mac_data   (mac_data),
      .mac_strb   (mac_strb),
      .mac_cmd    (mac_cmd),
      .mac_rdata  (mac_rdata),
      .mac_rvalid (mac_rvalid),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_err    (res_err),
      .busy       (busy)
   );

   always @(negedge clk) if (mac_cmd == 2'b11) rd_cycles++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".op_ready"},  op_ready,  1);
      chk({tag, ".busy"},      busy,      0);
      chk({tag, ".mac_strb"},  mac_strb,  0);
      chk({tag, ".mac_cmd"},   mac_cmd,   0);
      chk({tag, ".mac_data"},  mac_data,  0);
      chk({tag, ".res_valid"}, res_valid, 0);
      chk({tag, ".res_err"},   res_err,   0);
      chk({tag, ".res_data"},  res_data,  0);
   endtask

   task automatic send(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic last);
      @(negedge clk);
      op_a = a; op_b = b; op_last = last; op_valid = 1'b1;
      @(posedge clk);
      #1 op_valid = 1'b0;
   endtask

   // Checks the four byte cycles following acceptance.
   task automatic chk_bytes(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      logic [7:0] exp_b [4];
      exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("%s.strb%0d", tag, i), mac_strb, 1);
         chk($sformatf("%s.cmd%0d",  tag, i), mac_cmd, (i < 2) ? 1 : 2);
         chk($sformatf("%s.data%0d", tag, i), mac_data, exp_b[i]);
         chk($sformatf("%s.rdy%0d",  tag, i), op_ready, 0);
      end
   endtask

   initial begin
      int n;
      #1 rst = 1'b1;
      #2 chk_reset("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Non-last pair: bytes on cycles 1-4, ready again on cycle 5
      send(16'h3F80, 16'h4000, 1'b0);
      chk_bytes("pair", 8'h3F, 8'h80, 8'h40, 8'h00);
      @(negedge clk);
      chk("pair.rdy5", op_ready, 1);
      chk("pair.strb5", mac_strb, 0);
      chk("pair.busy5", busy, 0);

      // Last pair with readback 0x40, 3 idle cycles, 0xC0
      rd_cycles = 0;
      send(16'h4000, 16'h4040, 1'b1);
      chk_bytes("acc", 8'h40, 8'h00, 8'h40, 8'h40);
      @(negedge clk);
      chk("acc.req_strb", mac_strb, 1);
      chk("acc.req_cmd", mac_cmd, 3);
      chk("acc.req_data", mac_data, 0);
      @(negedge clk);
      chk("acc.recv_cmd", mac_cmd, 0);
      mac_rvalid = 1'b1; mac_rdata = 8'h40;
      @(negedge clk);
      mac_rvalid = 1'b0; mac_rdata = 8'h00;
      repeat (2) @(negedge clk);
      chk("acc.no_res_early", res_valid, 0);
      @(negedge clk);
      mac_rvalid = 1'b1; mac_rdata = 8'hC0;
      @(negedge clk);
      mac_rvalid = 1'b0;
      chk("acc.res_valid", res_valid, 1);
      chk("acc.res_data", res_data, 16'h40C0);
      chk("acc.res_err", res_err, 0);
      chk("acc.rd_cycles", rd_cycles, 1);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("acc.done_rdy", op_ready, 1);
      chk("acc.done_vld", res_valid, 0);

      // Result held under backpressure while op_valid stays high
      send(16'h1234, 16'h5678, 1'b1);
      chk_bytes("hold", 8'h12, 8'h34, 8'h56, 8'h78);
      @(negedge clk);
      @(negedge clk);
      mac_rvalid = 1'b1; mac_rdata = 8'hAB;
      @(negedge clk);
      mac_rdata = 8'hCD;
      @(negedge clk);
      mac_rvalid = 1'b0;
      op_valid = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; op_last = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("hold.vld%0d", i), res_valid, 1);
         chk($sformatf("hold.data%0d", i), res_data, 16'hABCD);
         chk($sformatf("hold.rdy%0d", i), op_ready, 0);
         @(negedge clk);
      end
      op_valid = 1'b0; res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("hold.rdy_after", op_ready, 1);
      chk("hold.vld_after", res_valid, 0);
      chk("hold.data_after", res_data, 0);
      @(negedge clk);
      chk("hold.no_capture", mac_strb, 0);
      chk("hold.idle_busy", busy, 0);

      // Timeout: no mac_rvalid after REQ
      send(16'h4000, 16'h4000, 1'b1);
      chk_bytes("tmo", 8'h40, 8'h00, 8'h40, 8'h00);
      @(negedge clk);
      chk("tmo.req_cmd", mac_cmd, 3);
      n = 0;
      while (!res_valid && n < 2 * TMO) begin
         @(negedge clk);
         n++;
      end
      chk("tmo.latency", n, TMO);
      chk("tmo.res_valid", res_valid, 1);
      chk("tmo.res_err", res_err, 1);
      chk("tmo.res_data", res_data, 0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("tmo.rdy_after", op_ready, 1);

      // Asynchronous reset during the second B byte
      send(16'h1122, 16'h3344, 1'b0);
      repeat (3) @(negedge clk);
      @(negedge clk);
      chk("rst.pre_data", mac_data, 8'h44);
      chk("rst.pre_cmd", mac_cmd, 2);
      rst = 1'b1;
      #1 chk_reset("rst.async");
      @(negedge clk);
      rst = 1'b0;
      send(16'h3F80, 16'h4000, 1'b0);
      chk_bytes("rst.retry", 8'h3F, 8'h80, 8'h40, 8'h00);
      @(negedge clk);
      chk("rst.retry_rdy", op_ready, 1);

      // Stray mac_rvalid while idle
      mac_rvalid = 1'b1; mac_rdata = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("stray.vld%0d", i), res_valid, 0);
         chk($sformatf("stray.busy%0d", i), busy, 0);
         chk($sformatf("stray.rdy%0d", i), op_ready, 1);
      end
      mac_rvalid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
